// File: rtl/bldc_commutator.sv
// bldc_commutator: six-step BLDC commutation engine with filtered halls, signed-duty PWM,
// dead-time gate sequencing, brake/coast, sticky invalid-hall fault and a signed step count.
//
// state | meaning
// DRIVE | phases hold the applied pattern; any target change starts dead time
// DEAD  | all gates off for DEAD_CYCLES cycles, then the latest target is applied
module bldc_commutator #(
  parameter int PWM_BITS    = 10,
  parameter int DEAD_CYCLES = 16,
  parameter int HALL_FILTER = 4,
  parameter int COUNT_BITS  = 32
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         brake,
  input  logic signed [PWM_BITS:0]     duty,
  input  logic                         clear_fault,
  input  logic [2:0]                   hall,
  output logic [5:0]                   phases,
  output logic                         fault,
  output logic                         hall_ready,
  output logic [2:0]                   hall_state,
  output logic                         hall_skip,
  output logic signed [COUNT_BITS-1:0] step_count
);

  localparam int FCNT_W = (HALL_FILTER < 1) ? 1 : $clog2(HALL_FILTER + 1);
  localparam logic [FCNT_W-1:0]   FILT_LEN  = FCNT_W'(HALL_FILTER);
  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
  localparam logic [7:0]          DEAD_LAST = 8'(DEAD_CYCLES - 1);

  typedef enum logic {ST_DRIVE, ST_DEAD} gate_state_t;

  function automatic logic hall_valid(input logic [2:0] h);
    return (h != 3'b000) && (h != 3'b111);
  endfunction

  function automatic logic [2:0] fwd_next(input logic [2:0] h);
    logic [2:0] n;
    case (h)
      3'b101:  n = 3'b100;
      3'b100:  n = 3'b110;
      3'b110:  n = 3'b010;
      3'b010:  n = 3'b011;
      3'b011:  n = 3'b001;
      3'b001:  n = 3'b101;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  // Returns {hiA,hiB,hiC,loA,loB,loC}; reverse direction swaps high and low sides.
  function automatic logic [5:0] comm_pattern(input logic [2:0] h, input logic rev);
    logic [2:0] hi;
    logic [2:0] lo;
    hi = 3'b000;
    lo = 3'b000;
    case (h)
      3'b101:  begin hi = 3'b100; lo = 3'b010; end
      3'b100:  begin hi = 3'b100; lo = 3'b001; end
      3'b110:  begin hi = 3'b010; lo = 3'b001; end
      3'b010:  begin hi = 3'b010; lo = 3'b100; end
      3'b011:  begin hi = 3'b001; lo = 3'b100; end
      3'b001:  begin hi = 3'b001; lo = 3'b010; end
      default: begin hi = 3'b000; lo = 3'b000; end
    endcase
    return rev ? {lo, hi} : {hi, lo};
  endfunction

  logic [2:0]           hall_s1;
  logic [2:0]           hall_s2;
  logic [1:0]           sync_vld;
  logic [2:0]           filt_val;
  logic [FCNT_W-1:0]    filt_cnt;
  logic [FCNT_W-1:0]    run_len;
  logic                 filt_load;
  logic [2:0]           hall_old;
  logic                 old_ready;
  logic                 hall_moved;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic signed [PWM_BITS:0] duty_lat;
  logic [PWM_BITS:0]    duty_abs;
  logic [PWM_BITS-1:0]  duty_mag;
  logic                 pwm_on;
  logic [5:0]           target;
  gate_state_t          gate_state;
  logic [7:0]           dead_cnt;

  always_ff @(posedge CLK) begin
    if (reset) begin
      hall_s1  <= 3'b000;
      hall_s2  <= 3'b000;
      sync_vld <= 2'b00;
    end else begin
      hall_s1  <= hall;
      hall_s2  <= hall_s1;
      sync_vld <= {sync_vld[0], 1'b1};
    end
  end

  // Run length of identical synchronised samples, including the current one; the
  // post-reset contents of the synchroniser are not real samples and are not counted.
  always_comb begin
    run_len = '0;
    if (!sync_vld[1])
      run_len = '0;
    else if ((filt_cnt != '0) && (hall_s2 == filt_val))
      run_len = (filt_cnt == FILT_LEN) ? filt_cnt : filt_cnt + FCNT_W'(1);
    else
      run_len = FCNT_W'(1);
  end

  assign filt_load = (run_len == FILT_LEN);

  always_ff @(posedge CLK) begin
    if (reset) begin
      filt_val   <= 3'b000;
      filt_cnt   <= '0;
      hall_state <= 3'b000;
      hall_ready <= 1'b0;
    end else begin
      filt_cnt <= run_len;
      if (sync_vld[1])
        filt_val <= hall_s2;
      if (filt_load) begin
        hall_state <= hall_s2;
        hall_ready <= 1'b1;
      end
    end
  end

  assign hall_moved = hall_ready && old_ready && (hall_state != hall_old) &&
                      hall_valid(hall_state) && hall_valid(hall_old);

  always_ff @(posedge CLK) begin
    if (reset) begin
      hall_old   <= 3'b000;
      old_ready  <= 1'b0;
      step_count <= '0;
      hall_skip  <= 1'b0;
      fault      <= 1'b0;
    end else begin
      hall_old  <= hall_state;
      old_ready <= hall_ready;
      hall_skip <= 1'b0;
      if (hall_moved) begin
        if (fwd_next(hall_old) == hall_state)
          step_count <= step_count + COUNT_BITS'(1);
        else if (fwd_next(hall_state) == hall_old)
          step_count <= step_count - COUNT_BITS'(1);
        else
          hall_skip <= 1'b1;
      end
      // Set wins over clear so a persisting invalid value keeps the flag up.
      fault <= (hall_ready && !hall_valid(hall_state)) || (fault && !clear_fault);
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      pwm_cnt  <= '0;
      duty_lat <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == PWM_MAX)
        duty_lat <= duty;
    end
  end

  // The most-negative duty has magnitude 2^PWM_BITS and saturates to full scale.
  assign duty_abs = duty_lat[PWM_BITS] ? $unsigned(-duty_lat) : $unsigned(duty_lat);
  assign duty_mag = duty_abs[PWM_BITS] ? PWM_MAX : duty_abs[PWM_BITS-1:0];
  assign pwm_on   = (pwm_cnt < duty_mag);

  always_comb begin
    target = 6'b000000;
    if (!hall_ready || fault)
      target = 6'b000000;
    else if (brake)
      target = 6'b000111;
    else if (!enable || !pwm_on)
      target = 6'b000000;
    else
      target = comm_pattern(hall_state, duty_lat[PWM_BITS]);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      gate_state <= ST_DRIVE;
      phases     <= 6'b000000;
      dead_cnt   <= 8'd0;
    end else begin
      case (gate_state)
        ST_DRIVE: begin
          if (target != phases) begin
            phases     <= 6'b000000;
            dead_cnt   <= 8'd0;
            gate_state <= ST_DEAD;
          end
        end
        ST_DEAD: begin
          // Target changes here do not restart the window; the exit samples the latest one.
          if (dead_cnt == DEAD_LAST) begin
            phases     <= target;
            gate_state <= ST_DRIVE;
          end else begin
            dead_cnt <= dead_cnt + 8'd1;
          end
        end
        default: begin
          phases     <= 6'b000000;
          gate_state <= ST_DRIVE;
        end
      endcase
    end
  end

endmodule

// File: doc/bldc_commutator.md
# bldc_commutator

Parametrised six-step BLDC commutation engine for the motor board, driven from the 16 MHz `CLK` domain. It filters the three hall inputs and produces a signed-duty PWM. It inserts dead time on every gate-pattern change and supports coast, brake and fault shutdown. It also keeps a signed hall-step position count for the control loop and the UART status frame.

## Interface
- `PWM_BITS`, 10, PWM counter width; period = 2^PWM_BITS cycles.
- `DEAD_CYCLES`, 16, all-off cycles inserted on any gate change; legal range is 1 to 255.
- `HALL_FILTER`, 4, consecutive equal synchronised samples required to accept a hall value; minimum 1.
- `COUNT_BITS`, 32, width of the step counter.
- `CLK` in 1: system clock, single clock domain.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: 0 = coast (all gates off).
- `brake` in 1: 1 = all low sides on; overrides duty.
- `duty` in PWM_BITS+1: signed duty; sign = direction, magnitude = on-cycles per period.
- `clear_fault` in 1: single-cycle pulse that clears `fault`.
- `hall` in 3: raw hall pins {H1,H2,H3}; asynchronous.
- `phases` out 6: {hiA,hiB,hiC,loA,loB,loC}; registered.
- `fault` out 1: sticky invalid-hall flag.
- `hall_ready` out 1: a filtered hall value exists.
- `hall_state` out 3: filtered hall value.
- `hall_skip` out 1: one-cycle pulse on a non-adjacent hall transition.
- `step_count` out COUNT_BITS: signed hall-step position.

## Operation
- **Hall path.**
  - Two-flop synchroniser feeds the filter.
  - `hall_state` loads the synchronised value after it has been equal for HALL_FILTER consecutive cycles.
  - `hall_ready` sets on the first load.
- **Invalid hall.** A filtered value of 000 or 111 sets `fault`.
  - `fault` is cleared only by `reset` or `clear_fault`.
  - If the invalid condition persists, `fault` stays set.
- **Forward hall sequence:** 101→100→110→010→011→001→101.
  - Transition to the next value: `step_count` +1.
  - Transition to the previous value: `step_count` −1.
  - Any other change between valid values: `hall_skip` pulses, count unchanged.
  - `step_count` wraps two's-complement.
- **Duty latch.**
  - `pwm_cnt` counts 0..2^PWM_BITS−1 and wraps.
  - `duty` is latched when `pwm_cnt` is at its maximum, so mid-period changes take effect on the next period.
  - Magnitude = |duty|, saturating at 2^PWM_BITS−1 (most-negative `duty` gives full magnitude).
  - `pwm_on` = `pwm_cnt` < magnitude.
- **Target pattern, by priority:**
  1. `!hall_ready` or `fault` → 000000.
  2. `brake` → 000111.
  3. `!enable` or `!pwm_on` → 000000.
  4. Otherwise drive from the commutation table.
- **Commutation table (forward):**
  - 101: A high, B low.
  - 100: A high, C low.
  - 110: B high, C low.
  - 010: B high, A low.
  - 011: C high, A low.
  - 001: C high, B low.
  - Negative duty swaps the high and low phase of each entry.
- **Gate FSM:**
  - DRIVE: `phases` = held pattern. If target ≠ `phases`: `phases` ← 0, dead counter ← 0, go to DEAD.
  - DEAD: `phases` held at 0 and the counter increments. On the DEAD_CYCLES-th cycle, `phases` ← the current target (sampled then), go to DRIVE.
  - A target change during DEAD does not restart the counter; the latest target is applied at exit.
  - High and low side of one phase are never both 1.

## Timing
- **Reset values:**
  - Outputs: `phases`=0, `fault`=0, `hall_ready`=0, `hall_state`=000, `hall_skip`=0, `step_count`=0.
  - Internal: `pwm_cnt`=0, latched duty=0, FSM=DRIVE.
  - The synchroniser and filter are cleared.
- **Hall latency.** A raw change sampled at edge k appears on `hall_state` at edge k+1+HALL_FILTER.
  - `step_count`, `hall_skip` and `fault` update one cycle later.
- **Gate latency.** Target change at cycle t (FSM in DRIVE):
  - `phases`=0 from t+1 through t+DEAD_CYCLES.
  - New pattern from t+DEAD_CYCLES+1.
- **Narrow duty.** An on-window shorter than DEAD_CYCLES produces no gate pulse. This is accepted behaviour.
- **Simultaneous fault and `clear_fault`:** `fault` stays set.
- **Reset mid-DEAD or mid-period:** all state returns to reset values on the next edge.

## Test plan
- **Forward drive.** PWM_BITS=10, DEAD=4, FILTER=3, enable=1, duty=+512, hall=101 held.
  - Expect `phases`=100010 for cnt 0..511 (minus dead windows), else 0.
  - Expect exactly 4 all-zero cycles before each on-edge.
- **Reverse rotation.** duty=−512, hall stepped 101→001→011.
  - Expect `step_count` −2.
  - Expect `phases` at hall 101 = 010100.
- **Filter rejection.** A 2-cycle glitch to 100 is ignored; a held change updates `hall_state` at k+4.
- **Invalid hall.** hall=111 → `fault`=1 and `phases` forced to 0.
  - Pulse `clear_fault` while 111 is held → `fault` stays 1.
  - Restore 101, then pulse → 0.
- **Skip.** 101→110 → one `hall_skip` pulse, `step_count` unchanged.
- **Brake and duty latch.**
  - `brake`=1 → `phases`=000111 after DEAD.
  - A duty write at cnt=100 takes effect at the next cnt=0.
  - duty=−1024 → full on.
